// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Constants and types shared between the serial FIR filter and its sample
// feeder. Sample width and tap count must stay identical on both sides,
// so both blocks take them from here.
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_WIDTH   = 20;                  // signed sample width
  localparam int FIR_TAPS    = 128;                 // filter cycles per output sample
  localparam int FIR_DEPTH   = 8;                   // feeder FIFO depth
  localparam int FIR_PHASE_W = $clog2(FIR_TAPS);    // tap/phase counter width

  // Feeder control state: IDLE until the first sample can be issued on a
  // frame boundary, then RUN for as long as the block is out of reset.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } feeder_state_e;

endpackage

// File: rtl/fir_sample_feeder_if.sv
// -----------------------------------------------------------------------------
// fir_sample_feeder_if
// Bundles the upstream valid/ready sample stream and the filter-facing
// outputs of the feeder.
//   master : upstream sample source (drives s_data/s_valid, observes the rest)
//   slave  : the feeder itself
// Signals: s_data, s_valid, s_ready, fir_input_sig, fir_ready,
//          sample_strobe, fifo_level.
// -----------------------------------------------------------------------------
interface fir_sample_feeder_if #(
  parameter int WIDTH = fir_pkg::FIR_WIDTH,
  parameter int DEPTH = fir_pkg::FIR_DEPTH
);
  logic signed [WIDTH-1:0]       s_data;
  logic                          s_valid;
  logic                          s_ready;
  logic signed [WIDTH-1:0]       fir_input_sig;
  logic                          fir_ready;
  logic                          sample_strobe;
  logic [$clog2(DEPTH):0]        fifo_level;

  modport master (
    output s_data, s_valid,
    input  s_ready, fir_input_sig, fir_ready, sample_strobe, fifo_level
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, fir_input_sig, fir_ready, sample_strobe, fifo_level
  );
endinterface

// File: rtl/fir_sample_fifo.sv
// -----------------------------------------------------------------------------
// fir_sample_fifo
// Generic synchronous first-word-fall-through FIFO with registered storage.
// A word written at edge t is on o_head during cycle t+1. o_head reads 0
// while empty. Pushes while full and pops while empty are ignored.
// Ports: clk, rst_n (async active-low), i_push/i_data, i_pop,
//        o_head, o_level (0..DEPTH), o_full, o_empty.
// -----------------------------------------------------------------------------
module fir_sample_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == {LW{1'b0}});
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_level = r_level;
  assign o_head  = o_empty ? {WIDTH{1'b0}} : r_mem[r_rptr];

  // Storage write; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
      r_wptr <= {AW{1'b0}};
    end else if (w_push) begin
      r_mem[r_wptr] <= i_data;
      r_wptr        <= r_wptr + AW'(1);
    end
  end

  // Read pointer and occupancy; a simultaneous push and pop leaves the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= {AW{1'b0}};
      r_level <= {LW{1'b0}};
    end else begin
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// -----------------------------------------------------------------------------
// fir_sample_feeder
// Upstream stage of the serial FIR filter. Buffers incoming samples and
// clocks the filter through fir_ready so that each sample is on
// fir_input_sig exactly when the filter latches it (phase TAPS-1).
// The internal phase counter mirrors the filter's tap counter, so the filter
// must only ever advance through this block's fir_ready.
// Ports: clk, rst_n (async active-low), bus (fir_sample_feeder_if.slave),
//        underrun_cnt (only with FIR_FEEDER_ZERO_FILL_EN).
// Optional build macro FIR_FEEDER_ZERO_FILL_EN: never stall the filter in
// RUN; an empty frame boundary feeds a zero sample and counts an underrun.
// -----------------------------------------------------------------------------
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_WIDTH,
  parameter int TAPS  = FIR_TAPS,
  parameter int DEPTH = FIR_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  fir_sample_feeder_if.slave  bus
`ifdef FIR_FEEDER_ZERO_FILL_EN
  ,
  output logic [15:0]         underrun_cnt
`endif
);
  localparam int PW = $clog2(TAPS);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(TAPS - 1);

  feeder_state_e    r_state;
  feeder_state_e    w_state_nxt;
  logic [PW-1:0]    r_phase;
  logic [LW-1:0]    w_level;
  logic [WIDTH-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_boundary;
  logic             w_push;
  logic             w_pop;
  logic             w_fir_ready;
  logic             w_strobe;

  assign w_boundary = (r_phase == LAST_PHASE);
  // s_ready comes from registered occupancy only, so a full FIFO refuses a
  // push even on the cycle it pops.
  assign w_push     = bus.s_valid && !w_full;

  fir_sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.s_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, filter advance, strobe and pop decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_fir_ready = 1'b0;
    w_strobe    = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_boundary && !w_empty) w_state_nxt = ST_RUN;
        else                        w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
`ifdef FIR_FEEDER_ZERO_FILL_EN
        w_fir_ready = 1'b1;
`else
        // Hold the filter on its last tap until a sample is available.
        w_fir_ready = !w_boundary || !w_empty;
`endif
        w_strobe    = w_fir_ready && w_boundary;
        w_pop       = w_strobe && !w_empty;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Phase counter, a shadow of the filter's tap index (wraps TAPS-1 -> 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_phase <= LAST_PHASE;
    else if (w_fir_ready) r_phase <= r_phase + PW'(1);
  end

`ifdef FIR_FEEDER_ZERO_FILL_EN
  logic [15:0] r_underrun;

  // Saturating count of boundaries that fed a zero instead of a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           r_underrun <= 16'h0000;
    else if (w_strobe && w_empty && r_underrun != 16'hFFFF) r_underrun <= r_underrun + 16'h0001;
  end

  assign underrun_cnt = r_underrun;
`endif

  assign bus.s_ready       = !w_full;
  assign bus.fir_input_sig = w_head;
  assign bus.fir_ready     = w_fir_ready;
  assign bus.sample_strobe = w_strobe;
  assign bus.fifo_level    = w_level;

endmodule
